// File: rtl/key_debounce_array_if.sv
// Purpose: bundles the raw key inputs and the debounced level/event outputs of key_debounce_array.
// Latency: none; wiring only.
// Backpressure: none; outputs are free-running levels and one-cycle pulses with no ready signal.
interface key_debounce_array_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;       // raw, asynchronous button inputs
    logic [N_KEYS-1:0] key_state;    // debounced level, 1 = pressed
    logic [N_KEYS-1:0] key_press;    // one-cycle pulse on debounced 0->1
    logic [N_KEYS-1:0] key_release;  // one-cycle pulse on debounced 1->0
    logic [N_KEYS-1:0] key_long;     // one-cycle pulse once a press has been held long enough
    logic              key_any;      // OR of key_state, cycle-aligned with it

    // Button side / user-interface side: drives the keys, consumes the events.
    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_any
    );

    // Debouncer side.
    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output key_any
    );
endinterface

// File: rtl/key_debounce_array.sv
// Purpose: per-channel 2-flop sync, polarity normalisation, debounce, press/release/long-press pulses.
// Latency: a clean input change shows on key_state and its pulse DEBOUNCE_CYCLES+2 cycles after the transition.
// Backpressure: none; every channel runs freely and independently, events are never stalled or queued.
module key_debounce_array #(
    parameter int N_KEYS            = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_array_if.slave  kif
);

    // Counter widths follow the cycle parameters; a 1-bit floor keeps the
    // disabled long-press case (LONG_PRESS_CYCLES == 0) legal.
    localparam int DCW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LCW         = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int LP_LAST_INT = (LONG_PRESS_CYCLES > 0) ? (LONG_PRESS_CYCLES - 1) : 0;
    localparam bit LONG_EN     = (LONG_PRESS_CYCLES != 0);

    localparam logic [DCW-1:0]    DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCW-1:0]    LP_LAST = LCW'(LP_LAST_INT);
    localparam logic [N_KEYS-1:0] KEY_INV = {N_KEYS{ACTIVE_LOW}};

    // Synchroniser: polarity is normalised before the first flop so that an
    // idle-high active-low key looks like "released" (0) straight out of reset.
    logic [N_KEYS-1:0] key_norm;
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    // Debounced level and per-channel counters.
    logic [N_KEYS-1:0] state_q;
    logic [N_KEYS-1:0] state_d;
    logic [DCW-1:0]    dcnt_q [N_KEYS];
    logic [DCW-1:0]    dcnt_d [N_KEYS];
    logic [LCW-1:0]    lcnt_q [N_KEYS];
    logic [LCW-1:0]    lcnt_d [N_KEYS];

    // long_done remembers that key_long already fired for the current press,
    // because lcnt saturates and would otherwise keep matching LP_LAST.
    logic [N_KEYS-1:0] long_done_q;
    logic [N_KEYS-1:0] long_done_d;

    // Registered event pulses.
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] long_q;
    logic [N_KEYS-1:0] long_d;
    logic              any_q;
    logic              any_d;

    assign key_norm = kif.key_in ^ KEY_INV;

    // Two-flop synchroniser for every raw key input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_norm;
            sync2_q <= sync1_q;
        end
    end

    // Next-state for debounce, long-press and the event pulses of every channel.
    always_comb begin
        state_d     = state_q;
        long_done_d = long_done_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            dcnt_d[i] = '0;
            lcnt_d[i] = '0;

            // Debounce: count only while the synchronised input disagrees
            // with the debounced level; any agreement restarts the window.
            if (sync2_q[i] != state_q[i]) begin
                if (dcnt_q[i] == DC_LAST) begin
                    state_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DCW'(1);
                end
            end

            // Long press: count the held time from the press edge, saturate,
            // and fire once. A release landing on the same edge wins so that
            // release and long never pulse together.
            if (LONG_EN) begin
                if (state_q[i]) begin
                    lcnt_d[i] = (lcnt_q[i] == LP_LAST) ? lcnt_q[i] : (lcnt_q[i] + LCW'(1));
                    if ((lcnt_q[i] == LP_LAST) && !long_done_q[i] && !release_d[i]) begin
                        long_d[i]      = 1'b1;
                        long_done_d[i] = 1'b1;
                    end
                end else begin
                    long_done_d[i] = 1'b0;
                end
            end
        end
        any_d = |state_d;
    end

    // State, counters and pulse registers; reset clears every count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            long_done_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            any_q       <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                dcnt_q[i] <= '0;
                lcnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            any_q       <= any_d;
            for (int i = 0; i < N_KEYS; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                lcnt_q[i] <= lcnt_d[i];
            end
        end
    end

    assign kif.key_state   = state_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.key_any     = any_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Purpose: directed, self-checking bench for key_debounce_array (active-high and active-low instances).
// Latency: inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: not applicable; the bench steps a fixed number of cycles per check.
`timescale 1ns/1ps
module tb_key_debounce_array;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int LP = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    key_debounce_array_if #(.N_KEYS(NK)) kif ();
    key_debounce_array_if #(.N_KEYS(NK)) kif_al ();

    key_debounce_array #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .kif(kif)
    );

    key_debounce_array #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .kif(kif_al)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Active-low instance must stay completely quiet while its keys idle high.
    logic al_watch = 1'b1;
    logic al_bad   = 1'b0;
    always @(negedge clk) begin
        if (al_watch && (|{kif_al.key_state, kif_al.key_press, kif_al.key_release,
                           kif_al.key_long, kif_al.key_any}))
            al_bad = 1'b1;
    end

    // Packed view {state, press, release, long, any}.
    function automatic logic [16:0] outs_main();
        return {kif.key_state, kif.key_press, kif.key_release, kif.key_long, kif.key_any};
    endfunction

    function automatic logic [16:0] outs_al();
        return {kif_al.key_state, kif_al.key_press, kif_al.key_release, kif_al.key_long, kif_al.key_any};
    endfunction

    function automatic logic [16:0] exp_o(input logic [3:0] st, input logic [3:0] pr,
                                          input logic [3:0] rl, input logic [3:0] lg,
                                          input logic an);
        return {st, pr, rl, lg, an};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (at %0t)", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] key;
        int         adv;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic       an;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Clean press on key 0, 3-cycle glitch (rejected), bouncy release.
        tbl[0]  = '{4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}; // idle after reset
        tbl[1]  = '{4'h1, 5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}; // +5: still debouncing
        tbl[2]  = '{4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1}; // +6: press pulse
        tbl[3]  = '{4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // pulse is one cycle
        tbl[4]  = '{4'h0, 3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // 3-cycle low glitch
        tbl[5]  = '{4'h1, 3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // glitch rejected
        tbl[6]  = '{4'h0, 2, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // release bounce: low 2
        tbl[7]  = '{4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // back high 1
        tbl[8]  = '{4'h0, 5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}; // final low +5
        tbl[9]  = '{4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0}; // final low +6: release
        tbl[10] = '{4'h0, 4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}; // single release only

        kif.key_in    = 4'h0;
        kif_al.key_in = 4'hF;

        // Asynchronous reset.
        #1 rst_n = 1'b0;
        #1;
        check("reset_main", outs_main(), 17'h0);
        check("reset_al",   outs_al(),   17'h0);
        step(3);
        check("reset_held_main", outs_main(), 17'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            kif.key_in = tbl[i].key;
            step(tbl[i].adv);
            check($sformatf("vec%0d", i), outs_main(),
                  exp_o(tbl[i].st, tbl[i].pr, tbl[i].rl, tbl[i].lg, tbl[i].an));
        end

        // Long press on key 2: key_long exactly LP edges after key_press, once.
        kif.key_in = 4'b0100;
        step(5);
        check("lp_pre", outs_main(), 17'h0);
        step(1);
        check("lp_press", outs_main(), exp_o(4'b0100, 4'b0100, 4'h0, 4'h0, 1'b1));
        for (int c = 1; c <= 25; c++) begin
            step(1);
            check($sformatf("lp_long_c%0d", c), kif.key_long, (c == LP) ? 4'b0100 : 4'b0000);
        end
        kif.key_in = 4'b0000;
        step(6);
        check("lp_release", outs_main(), exp_o(4'h0, 4'h0, 4'b0100, 4'h0, 1'b0));
        step(4);

        // Short hold (15 cycles of input): released before lcnt saturates.
        kif.key_in = 4'b0100;
        step(6);
        check("sh_press", kif.key_press, 4'b0100);
        for (int c = 1; c <= 9; c++) begin
            step(1);
            check($sformatf("sh_hold_c%0d", c), kif.key_long, 4'b0000);
        end
        kif.key_in = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            check($sformatf("sh_rel_c%0d", c),
                  {kif.key_long, kif.key_release, kif.key_state},
                  {4'b0000, (c == 6) ? 4'b0100 : 4'b0000, (c < 6) ? 4'b0100 : 4'b0000});
        end

        // Keys 1 and 3 together, key 1 bouncing for 2 cycles first.
        kif.key_in = 4'b1010;
        step(1);
        check("ind_c1", kif.key_press, 4'b0000);
        kif.key_in = 4'b1000;
        step(1);
        check("ind_c2", kif.key_press, 4'b0000);
        kif.key_in = 4'b1010;
        for (int c = 3; c <= 10; c++) begin
            step(1);
            check($sformatf("ind_press_c%0d", c), kif.key_press,
                  (c == 6) ? 4'b1000 : ((c == 8) ? 4'b0010 : 4'b0000));
        end
        check("ind_state", outs_main(), exp_o(4'b1010, 4'h0, 4'h0, 4'h0, 1'b1));
        kif.key_in = 4'b0000;
        step(6);
        check("ind_release", outs_main(), exp_o(4'h0, 4'h0, 4'b1010, 4'h0, 1'b0));
        step(3);

        // Reset mid-count: key 3 stable pressed, key 0 at dcnt=3.
        kif.key_in = 4'b1000;
        step(6);
        check("rm_key3", kif.key_state, 4'b1000);
        kif.key_in = 4'b1001;
        step(5);
        check("rm_before", kif.key_state, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("rm_async_clear", outs_main(), 17'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("rm_post_wait", outs_main(), 17'h0);
        step(1);
        check("rm_post_press", outs_main(), exp_o(4'b1001, 4'b1001, 4'h0, 4'h0, 1'b1));

        // Active-low instance: quiet through reset while idle high, then press key 0.
        al_watch = 1'b0;
        check("al_quiet", al_bad, 1'b0);
        kif_al.key_in = 4'hE;
        step(5);
        check("al_pre", outs_al(), 17'h0);
        step(1);
        check("al_press", outs_al(), exp_o(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b1));
        step(1);
        check("al_held", outs_al(), exp_o(4'b0001, 4'h0, 4'h0, 4'h0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
